// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: multicycle state enum, opcodes, mux/ALU/immediate selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_EXEC_LUI,
        ST_JALR,
        ST_JAL,
        ST_BRANCH,
        ST_ALU_WB,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_READ_DATA  = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wen;
        logic       adr_src;
        logic       ir_wen;
        logic       pc_wen;
        logic       gpr_wen;
        logic [1:0] alu_src_a_sel;
        logic [1:0] alu_src_b_sel;
        logic [1:0] alu_op;
        logic [2:0] imm_control;
        logic [1:0] result_src;
    } ctrl_t;

    // DECODE precomputes old_pc+imm, so the immediate must match the format that uses it.
    function automatic logic [2:0] decode_imm_sel(input logic [6:0] opcode);
        case (opcode)
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_AUIPC:  return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction feedback, memory handshake and control word.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_cond;
    logic       mem_req;
    logic       mem_wen;
    logic       adr_src;
    logic       ir_wen;
    logic       pc_wen;
    logic [1:0] alu_src_a_sel;
    logic [1:0] alu_src_b_sel;
    logic [1:0] alu_op;
    logic [2:0] imm_control;
    logic [1:0] result_src;
    logic       gpr_wen;

    modport master (
        input  opcode, mem_ready, branch_cond,
        output mem_req, mem_wen, adr_src, ir_wen, pc_wen,
               alu_src_a_sel, alu_src_b_sel, alu_op, imm_control, result_src, gpr_wen
    );

    modport slave (
        output opcode, mem_ready, branch_cond,
        input  mem_req, mem_wen, adr_src, ir_wen, pc_wen,
               alu_src_a_sel, alu_src_b_sel, alu_op, imm_control, result_src, gpr_wen
    );
endinterface

// File: rtl/mc_output_decoder.sv
// Control-word table: maps the current state (and IR opcode where needed) to raw datapath controls.
// Latency: purely combinational.
// Backpressure: none; handshake gating of the enables is applied by the caller.
module mc_output_decoder
    import riscv_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req       = 1'b1;
                ctrl.ir_wen        = 1'b1;
                ctrl.pc_wen        = 1'b1;
                ctrl.alu_src_a_sel = SRC_A_PC;
                ctrl.alu_src_b_sel = SRC_B_FOUR;
                ctrl.alu_op        = ALU_ADD;
                ctrl.result_src    = RES_ALU_RESULT;
            end
            ST_DECODE: begin
                ctrl.alu_src_a_sel = SRC_A_OLD_PC;
                ctrl.alu_src_b_sel = SRC_B_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.imm_control   = decode_imm_sel(opcode);
            end
            ST_MEM_ADR: begin
                ctrl.alu_src_a_sel = SRC_A_RS1;
                ctrl.alu_src_b_sel = SRC_B_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.imm_control   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            ST_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.result_src = RES_READ_DATA;
                ctrl.gpr_wen    = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_req     = 1'b1;
                ctrl.mem_wen     = 1'b1;
                ctrl.adr_src     = 1'b1;
                ctrl.imm_control = IMM_S;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a_sel = SRC_A_RS1;
                ctrl.alu_src_b_sel = SRC_B_RS2;
                ctrl.alu_op        = ALU_RTYPE;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a_sel = SRC_A_RS1;
                ctrl.alu_src_b_sel = SRC_B_IMM;
                ctrl.alu_op        = ALU_ITYPE;
                ctrl.imm_control   = IMM_I;
            end
            ST_EXEC_LUI: begin
                ctrl.alu_src_a_sel = SRC_A_ZERO;
                ctrl.alu_src_b_sel = SRC_B_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.imm_control   = IMM_U;
            end
            ST_ALU_WB: begin
                ctrl.result_src = RES_ALU_OUT;
                ctrl.gpr_wen    = 1'b1;
            end
            ST_JALR: begin
                ctrl.alu_src_a_sel = SRC_A_RS1;
                ctrl.alu_src_b_sel = SRC_B_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.imm_control   = IMM_I;
            end
            // PC takes the target held in alu_out while the ALU forms the link value.
            ST_JAL: begin
                ctrl.result_src    = RES_ALU_OUT;
                ctrl.pc_wen        = 1'b1;
                ctrl.alu_src_a_sel = SRC_A_OLD_PC;
                ctrl.alu_src_b_sel = SRC_B_FOUR;
                ctrl.alu_op        = ALU_ADD;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a_sel = SRC_A_RS1;
                ctrl.alu_src_b_sel = SRC_B_RS2;
                ctrl.alu_op        = ALU_SUB;
                ctrl.imm_control   = IMM_B;
                ctrl.result_src    = RES_ALU_OUT;
                ctrl.pc_wen        = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: state register, next-state logic, illegal flag and retired count.
// Latency: 3-5 cycles per instruction with zero wait states; outputs are Moore except fetch/branch PC writes.
// Backpressure: holds FETCH/MEM_READ/MEM_WRITE with mem_req stable until mem_ready.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus,
    output logic                    illegal,
    output logic [CNT_W-1:0]        instret
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   pc_gate;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:     if (bus.mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = ST_MEM_ADR;
                    OP_R:              state_nxt = ST_EXEC_R;
                    OP_I:              state_nxt = ST_EXEC_I;
                    OP_LUI:            state_nxt = ST_EXEC_LUI;
                    OP_AUIPC:          state_nxt = ST_ALU_WB;
                    OP_JAL:            state_nxt = ST_JAL;
                    OP_JALR:           state_nxt = ST_JALR;
                    OP_BRANCH:         state_nxt = ST_BRANCH;
                    default:           state_nxt = ST_TRAP;
                endcase
            end
            ST_MEM_ADR:   state_nxt = (bus.opcode == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  if (bus.mem_ready) state_nxt = ST_MEM_WB;
            ST_MEM_WB:    state_nxt = ST_FETCH;
            ST_MEM_WRITE: if (bus.mem_ready) state_nxt = ST_FETCH;
            ST_EXEC_R:    state_nxt = ST_ALU_WB;
            ST_EXEC_I:    state_nxt = ST_ALU_WB;
            ST_EXEC_LUI:  state_nxt = ST_ALU_WB;
            ST_ALU_WB:    state_nxt = ST_FETCH;
            ST_JALR:      state_nxt = ST_JAL;
            ST_JAL:       state_nxt = ST_ALU_WB;
            ST_BRANCH:    state_nxt = ST_FETCH;
            ST_TRAP:      state_nxt = ST_TRAP;
            default:      state_nxt = ST_FETCH;
        endcase
    end

    // Any arrival at FETCH from elsewhere is the end of a completed instruction.
    assign retire = (state_nxt == ST_FETCH) && (state != ST_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            if (retire) begin
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (state_nxt == ST_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    mc_output_decoder u_dec (
        .state  (state),
        .opcode (bus.opcode),
        .ctrl   (ctrl)
    );

    always_comb begin
        pc_gate = 1'b1;
        if (state == ST_FETCH) begin
            pc_gate = bus.mem_ready;
        end else if (state == ST_BRANCH) begin
            pc_gate = bus.branch_cond;
        end
    end

    // Reset suppresses every write-side enable so an abandoned instruction leaves no trace.
    assign bus.mem_req       = !rst && ctrl.mem_req;
    assign bus.mem_wen       = !rst && ctrl.mem_wen;
    assign bus.ir_wen        = !rst && ctrl.ir_wen && bus.mem_ready;
    assign bus.pc_wen        = !rst && ctrl.pc_wen && pc_gate;
    assign bus.gpr_wen       = !rst && ctrl.gpr_wen;
    assign bus.adr_src       = ctrl.adr_src;
    assign bus.alu_src_a_sel = ctrl.alu_src_a_sel;
    assign bus.alu_src_b_sel = ctrl.alu_src_b_sel;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.imm_control   = ctrl.imm_control;
    assign bus.result_src    = ctrl.result_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step-plan model plus directed literal pins and random traffic.
module tb_multicycle_controller;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int K_F = 0, K_D = 1, K_MA = 2, K_MR = 3, K_MWB = 4, K_MW = 5, K_ER = 6;
    localparam int K_EI = 7, K_EL = 8, K_WB = 9, K_JR = 10, K_J = 11, K_B = 12, K_T = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       illegal;
    logic [3:0] instret;

    multicycle_controller_if bus_if ();

    multicycle_controller #(.CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .illegal (illegal),
        .instret (instret)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         chk_en   = 1'b0;
    int         plan[$];
    int         m_instret = 0;
    bit         m_illegal = 1'b0;
    logic [6:0] cur_opc   = 7'd0;
    logic [6:0] next_opc  = 7'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int kind_now();
        return (plan.size() == 0) ? K_F : plan[0];
    endfunction

    // Remaining steps of an instruction once its opcode is known.
    task automatic load_plan(input logic [6:0] op);
        plan.delete();
        case (op)
            OPC_LOAD:   begin plan.push_back(K_MA); plan.push_back(K_MR); plan.push_back(K_MWB); end
            OPC_STORE:  begin plan.push_back(K_MA); plan.push_back(K_MW); end
            OPC_R:      begin plan.push_back(K_ER); plan.push_back(K_WB); end
            OPC_I:      begin plan.push_back(K_EI); plan.push_back(K_WB); end
            OPC_LUI:    begin plan.push_back(K_EL); plan.push_back(K_WB); end
            OPC_AUIPC:  plan.push_back(K_WB);
            OPC_JAL:    begin plan.push_back(K_J); plan.push_back(K_WB); end
            OPC_JALR:   begin plan.push_back(K_JR); plan.push_back(K_J); plan.push_back(K_WB); end
            OPC_BRANCH: plan.push_back(K_B);
            default:    plan.push_back(K_T);
        endcase
    endtask

    // Expected {mem_req,mem_wen,adr_src,ir_wen,pc_wen,gpr_wen,a,b,alu_op,imm,result_src}.
    function automatic logic [16:0] exp_word(input int k, input logic [6:0] op, input logic mr,
                                             input logic bc, input logic r);
        logic       mq, mw, ad, ir, pc, gw;
        logic [1:0] a, b, alu, res;
        logic [2:0] imm;
        mq = 0; mw = 0; ad = 0; ir = 0; pc = 0; gw = 0;
        a = 0; b = 0; alu = 0; res = 0; imm = 0;
        case (k)
            K_F:   begin mq = 1; ir = mr; pc = mr; b = 2'b10; res = 2'b10; end
            K_D:   begin
                a = 2'b01; b = 2'b01;
                imm = (op == OPC_BRANCH) ? 3'b010 : (op == OPC_JAL) ? 3'b100 :
                      (op == OPC_AUIPC) ? 3'b011 : 3'b000;
            end
            K_MA:  begin a = 2'b10; b = 2'b01; imm = (op == OPC_STORE) ? 3'b001 : 3'b000; end
            K_MR:  begin mq = 1; ad = 1; end
            K_MWB: begin res = 2'b01; gw = 1; end
            K_MW:  begin mq = 1; mw = 1; ad = 1; imm = 3'b001; end
            K_ER:  begin a = 2'b10; alu = 2'b10; end
            K_EI:  begin a = 2'b10; b = 2'b01; alu = 2'b11; end
            K_EL:  begin a = 2'b11; b = 2'b01; imm = 3'b011; end
            K_WB:  gw = 1;
            K_JR:  begin a = 2'b10; b = 2'b01; end
            K_J:   begin pc = 1; a = 2'b01; b = 2'b10; end
            K_B:   begin a = 2'b10; alu = 2'b01; imm = 3'b010; pc = bc; end
            default: ;
        endcase
        if (r) begin mq = 0; mw = 0; ir = 0; pc = 0; gw = 0; end
        return {mq, mw, ad, ir, pc, gw, a, b, alu, imm, res};
    endfunction

    always @(posedge clk) begin
        int k;
        if (rst) begin
            plan.delete();
            m_instret = 0;
            m_illegal = 1'b0;
        end else begin
            k = kind_now();
            if (k == K_F) begin
                if (bus_if.mem_ready) begin
                    cur_opc = next_opc;
                    plan.push_back(K_D);
                end
            end else if (k == K_D) begin
                load_plan(bus_if.opcode);
                if (plan[0] == K_T) m_illegal = 1'b1;
            end else if (k == K_T) begin
                m_illegal = 1'b1;
            end else if (!((k == K_MR || k == K_MW) && !bus_if.mem_ready)) begin
                void'(plan.pop_front());
                if (plan.size() == 0) m_instret = (m_instret + 1) % 16;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl_word",
                {bus_if.mem_req, bus_if.mem_wen, bus_if.adr_src, bus_if.ir_wen, bus_if.pc_wen,
                 bus_if.gpr_wen, bus_if.alu_src_a_sel, bus_if.alu_src_b_sel, bus_if.alu_op,
                 bus_if.imm_control, bus_if.result_src},
                exp_word(kind_now(), bus_if.opcode, bus_if.mem_ready, bus_if.branch_cond, rst));
            chk("instret", instret, m_instret);
            chk("illegal", illegal, m_illegal);
        end
    end

    task automatic cyc(input logic r, input logic mr, input logic bc);
        @(posedge clk);
        #2;
        rst                = r;
        bus_if.mem_ready   = mr;
        bus_if.branch_cond = bc;
        bus_if.opcode      = (kind_now() == K_F) ? 7'($urandom) : cur_opc;
        #1;
    endtask

    function automatic logic [6:0] pick_opc();
        logic [6:0] ops [9];
        int         idx;
        ops = '{OPC_LOAD, OPC_STORE, OPC_R, OPC_I, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH};
        idx = $urandom_range(0, 9);
        return (idx == 9) ? 7'($urandom) : ops[idx];
    endfunction

    initial begin
        logic [3:0] gp, pp;
        logic [9:0] mrp, mq_act, ad_act, gw_act, exp_v;
        logic [2:0] pp3, gp3;
        logic       r;

        bus_if.mem_ready   = 1'b0;
        bus_if.branch_cond = 1'b0;
        bus_if.opcode      = 7'd0;

        cyc(1, 0, 0);
        chk_en = 1'b1;
        cyc(1, 1, 0);
        chk("rst_enables", {bus_if.mem_req, bus_if.ir_wen, bus_if.pc_wen}, 3'b000);
        chk("rst_instret", instret, 4'd0);
        chk("rst_illegal", illegal, 1'b0);

        // add: F, D, EXEC_R, ALU_WB
        next_opc = OPC_R;
        gp = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0);
            gp[i] = bus_if.gpr_wen;
            if (i == 3) begin
                chk("add_result_src", bus_if.result_src, 2'b00);
                chk("add_instret_before", instret, 4'd0);
            end
        end
        chk("add_gpr_pattern", gp, 4'b1000);

        // lw with 2 fetch waits and 3 read waits: 10 cycles
        next_opc = OPC_LOAD;
        mrp = 10'b1100011100;
        mq_act = '0; ad_act = '0; gw_act = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, mrp[i], 0);
            mq_act[i] = bus_if.mem_req;
            ad_act[i] = bus_if.adr_src;
            gw_act[i] = bus_if.gpr_wen;
            if (i == 0) chk("add_retired", instret, 4'd1);
        end
        exp_v = 10'b0111100111; chk("lw_mem_req", mq_act, exp_v);
        exp_v = 10'b0111100000; chk("lw_adr_src", ad_act, exp_v);
        exp_v = 10'b1000000000; chk("lw_gpr_wen", gw_act, exp_v);

        // beq taken then not taken
        for (int t = 1; t >= 0; t--) begin
            next_opc = OPC_BRANCH;
            pp3 = '0; gp3 = '0;
            for (int i = 0; i < 3; i++) begin
                cyc(0, 1, t[0]);
                pp3[i] = bus_if.pc_wen;
                gp3[i] = bus_if.gpr_wen;
            end
            chk(t ? "beq_t_pc_wen" : "beq_nt_pc_wen", pp3, t ? 3'b101 : 3'b001);
            chk("beq_gpr_wen", gp3, 3'b000);
        end

        // jal: F, D, JAL, ALU_WB
        next_opc = OPC_JAL;
        pp = '0; gp = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0);
            pp[i] = bus_if.pc_wen;
            gp[i] = bus_if.gpr_wen;
            if (i == 0) chk("lw_beq_retired", instret, 4'd4);
            if (i == 2) chk("jal_link_sel", {bus_if.alu_src_a_sel, bus_if.alu_src_b_sel}, 4'b0110);
        end
        chk("jal_pc_wen", pp, 4'b0101);
        chk("jal_gpr_wen", gp, 4'b1000);

        // illegal opcode: sticky TRAP
        next_opc = 7'b1111111;
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1);
            chk("trap_hold", {illegal, bus_if.mem_req, bus_if.mem_wen, bus_if.ir_wen,
                              bus_if.pc_wen, bus_if.gpr_wen}, 6'b100000);
        end
        chk("trap_instret", instret, 4'd5);

        // reset out of TRAP, then reset during a store wait
        next_opc = OPC_STORE;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("post_trap_fetch", {bus_if.mem_req, bus_if.adr_src, illegal, instret}, 7'b1000000);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("sw_wait", {bus_if.mem_req, bus_if.mem_wen, bus_if.adr_src}, 3'b111);
        cyc(1, 0, 0);
        chk("sw_rst_drop", {bus_if.mem_req, bus_if.mem_wen}, 2'b00);
        cyc(0, 0, 0);
        chk("sw_rst_fetch", {bus_if.mem_req, bus_if.mem_wen, bus_if.adr_src, instret}, 7'b1000000);

        // 4-bit counter wrap: 15 then 0
        for (int n = 0; n < 15; n++) begin
            next_opc = OPC_R;
            repeat (4) cyc(0, 1, 0);
        end
        cyc(0, 1, 0);
        chk("instret_15", instret, 4'd15);
        repeat (3) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("instret_wrap", instret, 4'd0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (kind_now() == K_F) next_opc = pick_opc();
            r = ($urandom_range(0, 299) == 0) || (kind_now() == K_T && $urandom_range(0, 15) == 0);
            cyc(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencer for the shared-datapath RISC-V core (RV32I base). It replaces per-instruction single-cycle control with a Moore state machine that steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback. Memory wait states are handled with a ready handshake. It also counts retired instructions and flags illegal opcodes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-high
- opcode  input  7  instruction register bits [6:0]; valid from DECODE onward
- mem_ready  input  1  memory completed the access requested this cycle
- branch_cond  input  1  datapath comparator result for current funct3 (1 = take)
- mem_req  output  1  memory access request
- mem_wen  output  1  store (only with mem_req)
- adr_src  output  1  memory address: 0 = PC, 1 = alu_out register
- ir_wen  output  1  load instruction register and old_pc
- pc_wen  output  1  load PC from result mux
- alu_src_a_sel  output  2  00 PC, 01 old_pc, 10 rs1, 11 zero
- alu_src_b_sel  output  2  00 rs2, 01 imm, 10 constant 4
- alu_op  output  2  00 add, 01 branch/sub, 10 R-type, 11 I-type ALU (to alu decoder)
- imm_control  output  3  000 I, 001 S, 010 B, 011 U, 100 J
- result_src  output  2  00 alu_out reg, 01 read-data reg, 10 ALU result direct
- gpr_wen  output  1  register file write
- illegal  output  1  sticky illegal-opcode flag
- instret  output  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_LUI, JALR, JAL, BRANCH, ALU_WB, TRAP.
- Unlisted outputs are 0. Don't-care fields drive 0.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. When mem_ready=1: ir_wen=1, pc_wen=1, go to DECODE. Otherwise hold with ir_wen/pc_wen=0.
- DECODE: a=01, b=01, alu_op=00, so alu_out ← old_pc+imm. imm_control is B for branch, J for jal, U for auipc, I otherwise.
- DECODE next state by opcode:
  - load/store → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111 → EXEC_LUI
  - 0010111 → ALU_WB
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - any other → TRAP
- MEM_ADR: a=10, b=01, alu_op=00, imm_control=I (load) or S (store). Go to MEM_READ or MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: result_src=01, gpr_wen=1. Go to FETCH.
- MEM_WRITE: mem_req=1, mem_wen=1, adr_src=1, imm_control=S. Wait for mem_ready, then FETCH.
- EXEC_R: a=10, b=00, alu_op=10. Go to ALU_WB.
- EXEC_I: a=10, b=01, alu_op=11, imm I. Go to ALU_WB.
- EXEC_LUI: a=11, b=01, alu_op=00, imm U. Go to ALU_WB.
- ALU_WB: result_src=00, gpr_wen=1. Go to FETCH.
- JALR: a=10, b=01, alu_op=00, imm I, so alu_out ← rs1+imm. Go to JAL. The datapath clears bit 0 of the target.
- JAL: result_src=00, pc_wen=1 (PC ← alu_out target). Also a=01, b=10, alu_op=00, so alu_out ← old_pc+4. Go to ALU_WB.
- BRANCH: a=10, b=00, alu_op=01, imm B, result_src=00, pc_wen=branch_cond. Go to FETCH.
- TRAP: all enables 0 and illegal=1. The FSM stays in TRAP until rst.
- instret increments by 1 on every transition into FETCH from a non-FETCH state. Reaching TRAP does not count. The counter wraps at 2^CNT_W modulo.

## Timing
- Reset (rst=1 at a clk edge): state ← FETCH, instret ← 0, illegal ← 0.
- While rst=1, all of mem_req, mem_wen, ir_wen, pc_wen and gpr_wen are forced to 0, regardless of state.
- Reset mid-instruction abandons it with no further writes. FETCH restarts on the first cycle with rst=0.
- Outputs are Moore: a function of registered state only, except:
  - ir_wen/pc_wen in FETCH, gated by mem_ready
  - pc_wen in BRANCH, gated by branch_cond
- Cycles per instruction with zero wait states:
  - branch 3, auipc 3
  - R/I-ALU 4, lui 4, store 4, jal 4
  - load 5, jalr 5
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. mem_ready is ignored in all other states.
- mem_req stays asserted and stable, along with adr_src and mem_wen, until the handshake completes.

## Structure
- The shared package riscv_pkg holds:
  - state enum (4-bit)
  - opcode localparams
  - imm_control, alu_op, alu_src_a/b and result_src encodings, shared with the single-cycle decoder and datapath
- One sub-module, mc_output_decoder: combinational state(+opcode) → control-word table. The top level holds the state register, next-state logic, illegal flag and instret counter.

## Test plan
- add x3,x1,x2 with mem_ready always 1 → states F,D,ER,WB. gpr_wen=1 exactly in cycle 4, result_src=00, instret 0→1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEM_READ:
  - total 10 cycles
  - mem_req steady, with adr_src=1 throughout MEM_READ
  - gpr_wen=1 only in MEM_WB
- beq, once with branch_cond=1 and once with branch_cond=0 → pc_wen=1/0 in cycle 3, gpr_wen never set. jal → pc_wen in JAL, then gpr_wen in ALU_WB with a=01/b=10 in the preceding cycle.
- opcode 7'b1111111 → TRAP next cycle, illegal=1 held for 20 cycles, no enables, instret unchanged. rst clears to FETCH.
- rst asserted in MEM_WRITE during a wait → mem_req/mem_wen drop that cycle, no store, state FETCH, instret=0. Preload instret near 2^CNT_W−1 (CNT_W=4) → 15 then 0 wrap.
